// File: rtl/nes_pad_pkg.sv
// Shared types for the NES pad responder.
// Button indices, pad state vector and shift FSM states.
package nes_pad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef logic [7:0] pad_state_t;

  typedef enum logic {
    LATCH = 1'b0,
    SHIFT = 1'b1
  } pad_fsm_t;

endpackage

// File: rtl/pad_debounce.sv
// One-button synchronizer + debouncer.
// Ports: clk, rst, i_btn (raw async), o_stable (debounced level).
module pad_debounce #(
  parameter logic [19:0] CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_stable
);

  localparam int CW = $clog2(CYCLES + 20'd1);

  logic          r_s1;
  logic          r_s2;
  logic          r_s;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_s) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(CYCLES - 20'd1)) begin
        // this increment would reach CYCLES: accept the new level
        r_s   <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_s;

endmodule

// File: rtl/nes_pad_responder.sv
// Emulated 4021 NES joypad: debounced buttons, A/B turbo, serial shift.
// Ports: clk, rst, btns, turbo_en, strobe, rd in; data, state out.
module nes_pad_responder
  import nes_pad_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [19:0] TURBO_PERIOD    = 20'd89000,
  parameter logic        DATA_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btns,
  input  logic [1:0] turbo_en,
  input  logic       strobe,
  input  logic       rd,
  output logic       data,
  output logic [7:0] state
);

  localparam int TW = $clog2(TURBO_PERIOD + 20'd1);

  pad_state_t w_stable;
  pad_state_t w_state_nxt;
  pad_state_t r_state;
  pad_state_t r_sr;
  pad_state_t w_sr_nxt;
  pad_fsm_t   r_fsm;
  pad_fsm_t   w_fsm_nxt;
  logic [TW-1:0] r_tcnt;
  logic       r_tp;
  logic       r_rd_q;
  logic       r_data;
  logic       w_rd_fall;

  for (genvar g = 0; g < 8; g++) begin : g_deb
    pad_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_btn    (btns[g]),
      .o_stable (w_stable[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
      r_tp   <= 1'b1;
    end else if (r_tcnt == TW'(TURBO_PERIOD - 20'd1)) begin
      r_tcnt <= '0;
      r_tp   <= ~r_tp;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = w_stable;
    w_state_nxt[BTN_A] = w_stable[BTN_A] & (~turbo_en[0] | r_tp);
    w_state_nxt[BTN_B] = w_stable[BTN_B] & (~turbo_en[1] | r_tp);
  end

  assign w_rd_fall = r_rd_q & ~rd;

  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      LATCH: if (!strobe) w_fsm_nxt = SHIFT;
      SHIFT: if (strobe)  w_fsm_nxt = LATCH;
      default: w_fsm_nxt = LATCH;
    endcase
  end

  // Load takes priority over a coincident rd falling edge.
  always_comb begin
    w_sr_nxt = r_sr;
    if (w_fsm_nxt == LATCH) begin
      w_sr_nxt = r_state;
    end else if (w_rd_fall) begin
      w_sr_nxt = {1'b1, r_sr[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
      r_fsm   <= LATCH;
      r_sr    <= '0;
      r_rd_q  <= 1'b0;
      r_data  <= DATA_ACTIVE_LOW;
    end else begin
      r_state <= w_state_nxt;
      r_fsm   <= w_fsm_nxt;
      r_sr    <= w_sr_nxt;
      r_rd_q  <= rd;
      r_data  <= r_sr[0] ^ DATA_ACTIVE_LOW;
    end
  end

  assign data  = r_data;
  assign state = r_state;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder.
// Two instances: normal polarity (u_dut) and inverted data (u_inv).
module tb_nes_pad_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btns;
  logic [1:0] turbo_en;
  logic       strobe;
  logic       rd;
  logic       data;
  logic [7:0] state;
  logic       data2;
  logic [7:0] state2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  nes_pad_responder #(
    .DEBOUNCE_CYCLES(20'd4),
    .TURBO_PERIOD   (20'd8),
    .DATA_ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .btns(btns), .turbo_en(turbo_en),
    .strobe(strobe), .rd(rd), .data(data), .state(state)
  );

  nes_pad_responder #(
    .DEBOUNCE_CYCLES(20'd4),
    .TURBO_PERIOD   (20'd8),
    .DATA_ACTIVE_LOW(1'b1)
  ) u_inv (
    .clk(clk), .rst(rst), .btns(btns), .turbo_en(turbo_en),
    .strobe(strobe), .rd(rd), .data(data2), .state(state2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  task automatic latch();
    strobe = 1'b1;
    tick();
    tick();
    strobe = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_all(input logic [7:0] b);
    logic e;
    latch();
    for (int i = 0; i < 10; i++) begin
      e = (i < 8) ? b[i] : 1'b1;
      chk($sformatf("bit%0d", i), {7'd0, data}, {7'd0, e});
      chk($sformatf("inv%0d", i), {7'd0, data2}, {7'd0, ~e});
      rd = 1'b1;
      tick();
      tick();
      chk($sformatf("hold%0d", i), {7'd0, data}, {7'd0, e});
      rd = 1'b0;
      tick();
      tick();
    end
  endtask

  initial begin
    logic       bad;
    logic       found;
    logic       prev;
    int         n;
    int         hi;
    int         lo;
    logic       s1ok;

    rst = 1'b1;
    btns = 8'h00;
    turbo_en = 2'b00;
    strobe = 1'b0;
    rd = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_data", {7'd0, data}, 8'h00);
    chk("rst_data_inv", {7'd0, data2}, 8'h01);
    chk("rst_state", state, 8'h00);

    btns = 8'hFF;
    repeat (10) tick();
    chk("state_ff", state, 8'hFF);
    latch();
    chk("data_pre_rst", {7'd0, data}, 8'h01);

    #3 rst = 1'b1;
    #1;
    chk("async_data", {7'd0, data}, 8'h00);
    chk("async_state", state, 8'h00);
    chk("async_inv", {7'd0, data2}, 8'h01);
    tick();
    tick();
    #3 rst = 1'b0;
    repeat (6) tick();
    chk("rel_state6", state, 8'h00);
    tick();
    chk("rel_state7", state, 8'hFF);
    chk("rel_sr_clr", {7'd0, data}, 8'h00);

    btns = 8'h85;
    repeat (10) tick();
    chk("state_85", state, 8'h85);
    chk("state2_85", state2, 8'h85);
    read_all(8'h85);

    btns = 8'h00;
    repeat (10) tick();
    chk("bounce_base", state, 8'h00);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btns[0] = ~btns[0];
      repeat (2) begin
        tick();
        if (state[0]) bad = 1'b1;
      end
    end
    btns[0] = 1'b1;
    repeat (6) begin
      tick();
      if (state[0]) bad = 1'b1;
    end
    chk("bounce_low", {7'd0, bad}, 8'h00);
    tick();
    chk("bounce_rise", {7'd0, state[0]}, 8'h01);

    btns = 8'h01;
    repeat (10) tick();
    strobe = 1'b1;
    tick();
    tick();
    strobe = 1'b0;
    rd = 1'b1;
    tick();
    strobe = 1'b1;
    rd = 1'b0;
    tick();
    strobe = 1'b0;
    tick();
    chk("prio_a", {7'd0, data}, 8'h01);
    rd = 1'b1;
    tick();
    tick();
    rd = 1'b0;
    tick();
    tick();
    chk("prio_b", {7'd0, data}, 8'h00);

    btns = 8'h03;
    repeat (10) tick();
    turbo_en = 2'b01;
    found = 1'b0;
    n = 0;
    s1ok = 1'b1;
    prev = state[0];
    while (!found && n < 40) begin
      tick();
      n++;
      if (!prev && state[0]) found = 1'b1;
      prev = state[0];
    end
    chk("turbo_edge", {7'd0, found}, 8'h01);
    hi = 1;
    lo = 0;
    repeat (7) begin
      tick();
      if (state[0]) hi++;
      if (!state[1]) s1ok = 1'b0;
    end
    repeat (8) begin
      tick();
      if (!state[0]) lo++;
      if (!state[1]) s1ok = 1'b0;
    end
    chk("turbo_hi", 8'(hi), 8'd8);
    chk("turbo_lo", 8'(lo), 8'd8);
    tick();
    chk("turbo_back", {7'd0, state[0]}, 8'h01);
    chk("turbo_b", {7'd0, s1ok}, 8'h01);

    turbo_en = 2'b00;
    repeat (3) tick();
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (state[1:0] != 2'b11) bad = 1'b1;
    end
    chk("turbo_off", {7'd0, bad}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nes_pad_responder.md
# nes_pad_responder

Controller-side end of the NES serial joypad protocol: emulates a standard 4021-based pad from eight raw push-button inputs, answering the console's latch strobe and read pulses with one serial button bit per read. It sits between board buttons and the `nes` core's `ctrl_strobe` / `ctrl_out` / `ctrl_data` port, replacing an external pad for bring-up and demo builds. Each button is synchronized and debounced, and A/B have optional turbo.

## Interface
- `DEBOUNCE_CYCLES`, default 20'd500000: consecutive stable cycles required before a button change is accepted.
- `TURBO_PERIOD`, default 20'd89000: half-period, in cycles, of the turbo square wave.
- `DATA_ACTIVE_LOW`, default 1'b0: 1 inverts `data` to match real-pad electrical polarity.
- `clk`, in, 1: clock; one clock drives the whole block.
- `rst`, in, 1: reset, asynchronous, active-high.
- `btns`, in, 8: raw asynchronous buttons, 1 = pressed, order {R,L,D,U,Start,Select,B,A}.
- `turbo_en`, in, 2: [0] = turbo on A, [1] = turbo on B; synchronous.
- `strobe`, in, 1: console latch, synchronous level.
- `rd`, in, 1: console read pulse, synchronous level; high while the console samples.
- `data`, out, 1: serial button bit (logical 1 = pressed before `DATA_ACTIVE_LOW` inversion).
- `state`, out, 8: debounced, turbo-applied button vector, for LEDs and debug.

## Operation
- Input path: two-flop synchronizer per `btns` bit, then per-button debounce.
- Debounce: per-bit counter with stable state `s`.
  - Synced input equal to `s`: counter = 0.
  - Otherwise: counter increments. Reaching `DEBOUNCE_CYCLES` sets `s` to the input and clears the counter.
  - Counter width is clog2(`DEBOUNCE_CYCLES`+1).
- Turbo: free-running counter 0..`TURBO_PERIOD`-1. At wrap, phase `tp` toggles.
  - `state[0]` = s[0] & (~turbo_en[0] | tp).
  - `state[1]` = s[1] & (~turbo_en[1] | tp).
  - `state[7:2]` = s[7:2].
- Shift register `sr[7:0]`, two-state FSM:
  - LATCH (strobe=1): `sr <= state` every cycle. `rd` is ignored.
  - SHIFT (strobe=0): on the `rd` falling edge (rd_q=1, rd=0), `sr <= {1'b1, sr[7:1]}`.
  - Transitions follow `strobe` directly.
- `data` = `sr[0]` ^ `DATA_ACTIVE_LOW`, registered. Reads 9+ return 1, matching an official pad.
- Simultaneous `strobe`=1 and `rd` falling edge: the load wins and no shift occurs.
- `rd` held high any length counts as one read. A glitch-free single-cycle pulse is legal.

## Timing
- Reset values:
  - `sr` = 8'h00; `data` = `DATA_ACTIVE_LOW`.
  - `state` = 0; debounce `s` = 0, counters = 0.
  - `tp` = 1, turbo counter = 0; `rd_q` = 0.
- Reset mid-read sequence: the next transaction starts from reset values. No partial shift survives.
- Button to `state`: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 register cycle.
- `strobe` high cycle N: `sr` holds `state` at N+1, and `data` shows A at N+2.
- `rd` falling edge detected at cycle N: `sr` shifts at N+1, and `data` shows the next bit at N+2.
- `data` is stable for the whole `rd`-high window. The console samples during `rd` high, and the shift occurs only after `rd` falls.
- Minimum `rd`-low gap between reads: 2 cycles.

## Structure
- Package `nes_pad_pkg`:
  - Button index constants `BTN_A`=0, `BTN_B`=1, `BTN_SELECT`=2, `BTN_START`=3, `BTN_UP`=4, `BTN_DOWN`=5, `BTN_LEFT`=6, `BTN_RIGHT`=7.
  - typedef `pad_state_t` (logic [7:0]).
  - enum `pad_fsm_t` {LATCH, SHIFT}.
- Sub-module `pad_debounce`:
  - Synchronizer plus counter for one bit, with a `CYCLES` parameter.
  - Instantiated 8× in a generate loop.
- Top of the block holds the turbo counter, FSM, shift register and output register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `TURBO_PERIOD`=8, `DATA_ACTIVE_LOW`=0.

- Reset: assert `rst` asynchronously mid-cycle with `btns`=8'hFF → `data`=0 and `state`=0 immediately. After release, `state`=8'hFF 7 cycles after inputs settle.
- Full read: `btns`=8'b1000_0101, strobe 1→0, 8 `rd` pulses (2 high / 2 low) → serial A..R = 1,0,1,0,0,0,0,1. Reads 9 and 10 = 1,1.
- Bounce: toggle `btns[0]` every 2 cycles for 20 cycles, then hold 1 → `state[0]` stays 0 during the toggling and rises exactly 7 cycles after the final edge.
- Strobe priority: `rd` falling edge in the same cycle as `strobe` rising with `btns`=8'h01 → no shift, and the next `data`=1 (A).
- Turbo: `btns[0]`=1, `turbo_en`=2'b01 → `state[0]` is a square wave with 8 cycles high / 8 low while `state[1]` is unaffected. With `turbo_en`=0, `state[0]` is steady 1.
- Polarity: `DATA_ACTIVE_LOW`=1, repeat the full read → every bit is inverted, and reset `data`=1.
